// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional misaligned-redirect trap: FETCH_ALIGN_CHK_EN.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, redirect input and
// the valid/ready handshake toward decode.
interface instr_fetch_unit_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// Two-entry in-order buffer of fetched {pc, instr}; entry 0 is the head.
// Storage only: the caller decides when to push, pop or flush.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t e0, e1;

  assign head = e0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e0    <= '0;
      e1    <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      unique case (1'b1)
        push && !pop: begin
          if (count == 2'd0) e0 <= din;
          else               e1 <= din;
          count <= count + 2'd1;
        end
        !push && pop: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        push && pop: begin
          if (count == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_ovf: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && !flush && count == 2'd2));

  a_no_udf: assert property (@(posedge clk) disable iff (!rst)
    !(pop && !flush && count == 2'd0));

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: one outstanding imem read, 2-entry skid buffer, redirects.
// FETCH_ALIGN_CHK_EN adds fetch_misalign and the HALT state.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  instr_fetch_unit_if.master bus
`ifdef FETCH_ALIGN_CHK_EN
  ,
  output logic fetch_misalign
`endif
);

  localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);

  state_e       state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  infl_pc;
  logic         infl_v;
  logic [31:0]  fetch_pc;
  logic [2:0]   occ;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t din;
  logic         deq, bad_rd, halted;
  logic         issue, push, pop;

  assign deq    = bus.out_valid & bus.out_ready;
  assign halted = (state_q == HALT);

`ifdef FETCH_ALIGN_CHK_EN
  assign bad_rd = bus.redirect_valid
                & (bus.redirect_pc[1:0] != 2'b00);
  assign fetch_misalign = halted;
`else
  assign bad_rd = 1'b0;
`endif

  assign fetch_pc = bus.redirect_valid
                  ? (bus.redirect_pc & ~32'h3)
                  : pc_q;

  assign bus.imem_addr = fetch_pc >> 2;

  // Slots that will be taken after this edge if nothing new is issued.
  assign occ = {1'b0, count}
             + {2'b00, infl_v}
             - {2'b00, deq};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.redirect_valid)
      state_d = bad_rd ? HALT : RUN;
  end

  always_comb begin
    issue = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    unique case (1'b1)
      bus.redirect_valid: begin
        issue = !bad_rd;
      end
      !bus.redirect_valid && halted: begin
        issue = 1'b0;
      end
      !bus.redirect_valid && !halted: begin
        issue = (occ < DEPTH);
        push  = infl_v;
        pop   = deq;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      infl_v  <= 1'b0;
      infl_pc <= 32'h0;
    end else begin
      infl_v <= issue;
      if (issue) begin
        infl_pc <= fetch_pc;
        pc_q    <= fetch_pc + 32'd4;
      end
    end
  end

  assign din.pc    = infl_pc;
  assign din.instr = bus.imem_instr;

  fetch_skid_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   (din),
    .count (count),
    .head  (head)
  );

  assign bus.out_valid = (count != 2'd0);
  assign bus.out_pc    = head.pc;
  assign bus.out_instr = head.instr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, corner sequences,
// and a random run against a stream-level scoreboard.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus();

`ifdef FETCH_ALIGN_CHK_EN
  logic fetch_misalign;
`endif

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_ALIGN_CHK_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  // Synchronous memory: word k holds A000_0000 + k.
  always @(posedge clk) bus.imem_instr <= 32'hA000_0000 + bus.imem_addr;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ein;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tv[$];
  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return 32'hA000_0000 + (pc >> 2);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rdy, input logic rv, input logic [31:0] rpc,
                     input logic ev, input logic [31:0] epc,
                     input logic [31:0] eaddr);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.ein = mem_word(epc);
    v.eaddr = eaddr;
    tv.push_back(v);
  endtask

  task automatic drive(input logic rdy, input logic rv,
                       input logic [31:0] rpc);
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  logic        rdy_r, rv_r, rd_prev, hold_v;
  logic [31:0] rpc_r, exp_pc, hold_pc, hold_in;
  int          gap;

  initial begin
    drive(1'b1, 1'b0, 32'h0);

    // rows: ready, redirect, target, exp valid, exp pc, exp imem_addr
    add(1, 0, 0,       0, 0,       32'h01);
    add(1, 0, 0,       1, 0,       32'h02);
    add(1, 0, 0,       1, 4,       32'h03);
    add(1, 0, 0,       1, 8,       32'h04);
    add(0, 0, 0,       1, 8,       32'h04);
    add(0, 0, 0,       1, 8,       32'h04);
    add(0, 0, 0,       1, 8,       32'h04);
    add(1, 0, 0,       1, 12,      32'h05);
    add(1, 0, 0,       1, 16,      32'h06);
    add(1, 0, 0,       1, 20,      32'h07);
    add(0, 0, 0,       1, 20,      32'h07);
    add(0, 0, 0,       1, 20,      32'h07);
    add(0, 1, 32'h40,  0, 0,       32'h10);
    add(1, 0, 0,       1, 32'h40,  32'h12);
    add(1, 0, 0,       1, 32'h44,  32'h13);
    add(1, 1, 32'h100, 0, 0,       32'h40);
    add(1, 0, 0,       1, 32'h100, 32'h42);
    add(1, 0, 0,       1, 32'h104, 32'h43);
`ifndef FETCH_ALIGN_CHK_EN
    add(1, 1, 32'h203, 0, 0,       32'h80);
    add(1, 0, 0,       1, 32'h200, 32'h82);
`endif

    #2;
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_pc",    bus.out_pc,         32'h0);
    chk("rst_instr", bus.out_instr,      32'h0);
    chk("rst_addr",  bus.imem_addr,      32'h0);
`ifdef FETCH_ALIGN_CHK_EN
    chk("rst_misalign", 32'(fetch_misalign), 32'h0);
`endif

    @(negedge clk);
    rst = 1'b1;
    foreach (tv[i]) begin
      drive(tv[i].rdy, tv[i].rv, tv[i].rpc);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(tv[i].ev));
      chk($sformatf("vec%0d_addr", i), bus.imem_addr, tv[i].eaddr);
      if (tv[i].ev) begin
        chk($sformatf("vec%0d_pc", i), bus.out_pc, tv[i].epc);
        chk($sformatf("vec%0d_instr", i), bus.out_instr, tv[i].ein);
      end
      @(negedge clk);
    end

`ifdef FETCH_ALIGN_CHK_EN
    drive(1'b1, 1'b1, 32'h42);
    @(posedge clk); #1;
    chk("mis_flag", 32'(fetch_misalign), 32'h1);
    chk("mis_valid", 32'(bus.out_valid), 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      chk("halt_flag", 32'(fetch_misalign), 32'h1);
      chk("halt_valid", 32'(bus.out_valid), 32'h0);
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h80);
    @(posedge clk); #1;
    chk("unhalt_flag", 32'(fetch_misalign), 32'h0);
    chk("unhalt_bubble", 32'(bus.out_valid), 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk("unhalt_valid", 32'(bus.out_valid), 32'h1);
    chk("unhalt_pc", bus.out_pc, 32'h80);
    chk("unhalt_instr", bus.out_instr, mem_word(32'h80));
    @(negedge clk);
`endif

    // Asynchronous reset in the middle of a streaming cycle.
    drive(1'b1, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("restart_e1_valid", 32'(bus.out_valid), 32'h0);
    @(posedge clk); #1;
    chk("restart_e2_valid", 32'(bus.out_valid), 32'h1);
    chk("restart_pc", bus.out_pc, 32'h0);
    chk("restart_instr", bus.out_instr, mem_word(32'h0));

    // Random traffic: every accepted instruction must be the next one
    // of the program-order stream, restarting at each redirect target.
    exp_pc  = 32'h0;
    rd_prev = 1'b0;
    hold_v  = 1'b0;
    hold_pc = 32'h0;
    hold_in = 32'h0;
    gap     = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (rd_prev)
        chk("rnd_bubble", 32'(bus.out_valid), 32'h0);
      if (hold_v) begin
        chk("rnd_hold_valid", 32'(bus.out_valid), 32'h1);
        chk("rnd_hold_pc", bus.out_pc, hold_pc);
        chk("rnd_hold_instr", bus.out_instr, hold_in);
      end
      if (!bus.out_valid && !rd_prev) gap++;
      else gap = 0;
      chk("rnd_gap_bound", 32'(gap > 3), 32'h0);

      rdy_r = ($urandom_range(0, 3) != 0);
      rv_r  = ($urandom_range(0, 15) == 0);
      rpc_r = $urandom_range(0, 32'hFFF);
      if ($urandom_range(0, 7) == 0) rpc_r = 32'hFFFF_FFF0;
`ifdef FETCH_ALIGN_CHK_EN
      rpc_r = rpc_r & ~32'h3;
`endif
      drive(rdy_r, rv_r, rpc_r);

      if (bus.out_valid && rdy_r) begin
        chk("rnd_pc", bus.out_pc, exp_pc);
        chk("rnd_instr", bus.out_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      hold_v  = bus.out_valid && !rdy_r && !rv_r;
      hold_pc = bus.out_pc;
      hold_in = bus.out_instr;
      if (rv_r) exp_pc = rpc_r & ~32'h3;
      rd_prev = rv_r;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
